// File: rtl/p_emap_pkg.sv
// p_emap_pkg: shared widths and FSM state type for the P-vector gather unit.
package p_emap_pkg;

    localparam int ELEM_W = 32;
    localparam int IDX_W  = 32;

    typedef enum logic {IDLE, EMIT} state_t;

endpackage

// File: rtl/p_emap_vector_ram.sv
// p_emap_vector_ram: P vector storage with one write port and NR combinational read ports.
//   clk_i   : clock, write on rising edge
//   we_i    : write strobe
//   waddr_i : write index
//   wdata_i : write value
//   raddr_i : NR packed read indices, port r at [r*AW +: AW]
//   rdata_o : NR packed read values,  port r at [r*W +: W]
// Reads are combinational from the current contents, so a read in the same
// cycle as a write to the same entry returns the old value (read-first).
module p_emap_vector_ram
    import p_emap_pkg::*;
#(
    parameter int W     = ELEM_W,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int NR    = 8
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [W-1:0]    wdata_i,
    input  logic [NR*AW-1:0] raddr_i,
    output logic [NR*W-1:0] rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    for (genvar r = 0; r < NR; r++) begin : g_rd
        assign rdata_o[r*W +: W] = mem_q[raddr_i[r*AW +: AW]];
    end

endmodule

// File: rtl/p_emap_8.sv
// p_emap_8: gathers P elements addressed by a bundle of column indices and streams them in groups.
//   clk                 : clock, rising edge
//   reset               : synchronous active-high reset
//   memories_preprocess : load strobe for col_nos and multiples
//   write_enable        : P write strobe
//   write_address       : P write index
//   write_data          : P write value
//   col_nos             : NC column indices, entry 0 in the MSBs
//   emap_row            : gathered group, slot 0 in the MSBs
//   multiples           : number of groups to emit for the bundle
//   you_can_read        : emap_row valid
// Optional feature macro: P_EMAP_BOUNDS_CHECK_EN -- indices >= p_depth gather 0
// instead of wrapping to their low address bits.
module p_emap_8
    import p_emap_pkg::*;
#(
    parameter int no_of_units               = 8,
    parameter int element_width             = ELEM_W,
    parameter int no_of_elements_on_col_nos = 20,
    parameter int no_of_elements_in_output  = 8,
    parameter int p_depth                   = 256
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        memories_preprocess,
    input  logic                                        write_enable,
    input  logic [$clog2(p_depth)-1:0]                  write_address,
    input  logic [element_width-1:0]                    write_data,
    input  logic [no_of_elements_on_col_nos*IDX_W-1:0]  col_nos,
    output logic [no_of_elements_in_output*element_width-1:0] emap_row,
    input  logic [31:0]                                 multiples,
    output logic                                        you_can_read
);

    localparam int W  = element_width;
    localparam int NC = no_of_elements_on_col_nos;
    localparam int NO = no_of_elements_in_output;
    localparam int AW = $clog2(p_depth);
    localparam int G  = (NC + NO - 1) / NO;
    localparam int KW = (G > 1) ? $clog2(G) : 1;
    localparam logic [KW:0] GL = (KW+1)'(G);

    if (no_of_units < 1 || NC < 1 || NO < 1) begin : g_bad_cfg
        $error("p_emap_8: lane and element counts must be positive");
    end

    state_t              state_q;
    logic [KW-1:0]       k_q;
    logic [KW:0]         m_q;
    logic [NC*IDX_W-1:0] col_q;
    logic [NO*W-1:0]     row_q;
    logic                vld_q;

    logic [KW:0]         m_d;
    logic                last;
    logic                load;

    // Per-group view of the latched bundle; slots past the bundle end are padding.
    logic [IDX_W-1:0]    ent [G][NO];
    logic [NO-1:0]       entv [G];

    for (genvar g = 0; g < G; g++) begin : g_grp
        for (genvar j = 0; j < NO; j++) begin : g_slot
            if (g*NO + j < NC) begin : g_real
                assign ent[g][j]  = col_q[(NC-1-(g*NO+j))*IDX_W +: IDX_W];
                assign entv[g][j] = 1'b1;
            end else begin : g_pad
                assign ent[g][j]  = '0;
                assign entv[g][j] = 1'b0;
            end
        end
    end

    logic [IDX_W-1:0]    sel [NO];
    logic [NO-1:0]       oob;
    logic [NO*AW-1:0]    raddr;
    logic [NO*W-1:0]     rdata;
    logic [NO*W-1:0]     row_d;

    always_comb begin
        raddr = '0;
        row_d = '0;
        oob   = '0;
        for (int j = 0; j < NO; j++) begin
            sel[j] = ent[k_q][j];
`ifdef P_EMAP_BOUNDS_CHECK_EN
            oob[j] = sel[j] >= IDX_W'(p_depth);
`else
            oob[j] = 1'b0;
`endif
            raddr[j*AW +: AW] = sel[j][AW-1:0];
            row_d[(NO-1-j)*W +: W] = (entv[k_q][j] && !oob[j]) ? rdata[j*W +: W] : '0;
        end
    end

    p_emap_vector_ram #(
        .W     (W),
        .DEPTH (p_depth),
        .AW    (AW),
        .NR    (NO)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (write_enable),
        .waddr_i (write_address),
        .wdata_i (write_data),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // A zero group count means there is nothing to emit, so such loads are dropped.
    assign m_d  = (multiples > 32'(G)) ? GL : multiples[KW:0];
    assign last = (state_q == EMIT) && ((KW+1)'(k_q) + (KW+1)'(1) == m_q);
    assign load = memories_preprocess && (m_d != '0) && ((state_q == IDLE) || last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            m_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= (state_q == EMIT);
            if (state_q == EMIT) row_q <= row_d;
            // The group being registered uses the old bundle, so reloading on the
            // last cycle is safe and keeps the output stream gap-free.
            if (load) begin
                col_q   <= col_nos;
                m_q     <= m_d;
                k_q     <= '0;
                state_q <= EMIT;
            end else if (state_q == EMIT) begin
                k_q     <= last ? '0 : k_q + KW'(1);
                state_q <= last ? IDLE : EMIT;
            end
        end
    end

    assign emap_row     = row_q;
    assign you_can_read = vld_q;

endmodule

// File: tb/tb_p_emap_8.sv
// tb_p_emap_8: table-driven and directed checks of the p_emap_8 gather unit.
module tb_p_emap_8;

    logic         clk = 1'b0;
    logic         reset;
    logic         memories_preprocess;
    logic         write_enable;
    logic [7:0]   write_address;
    logic [31:0]  write_data;
    logic [639:0] col_nos;
    logic [255:0] emap_row;
    logic [31:0]  multiples;
    logic         you_can_read;

    p_emap_8 dut (
        .clk                 (clk),
        .reset               (reset),
        .memories_preprocess (memories_preprocess),
        .write_enable        (write_enable),
        .write_address       (write_address),
        .write_data          (write_data),
        .col_nos             (col_nos),
        .emap_row            (emap_row),
        .multiples           (multiples),
        .you_can_read        (you_can_read)
    );

    always #5 clk = ~clk;

    logic [31:0] pm [256];
    logic [31:0] cv [20];
    int total = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] start;
        logic [31:0] step;
        logic [31:0] mult;
        int          nvalid;
    } vec_t;

    vec_t tbl [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [31:0] pval(input logic [31:0] idx);
`ifdef P_EMAP_BOUNDS_CHECK_EN
        return (idx >= 32'd256) ? 32'd0 : pm[idx[7:0]];
`else
        return pm[idx[7:0]];
`endif
    endfunction

    function automatic logic [255:0] exp_group(input int g);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < 8; j++)
            if (g*8 + j < 20) r[(7-j)*32 +: 32] = pval(cv[g*8 + j]);
        return r;
    endfunction

    task automatic pack;
        for (int e = 0; e < 20; e++) col_nos[(19-e)*32 +: 32] = cv[e];
    endtask

    task automatic set_cols(input logic [31:0] start, input logic [31:0] step);
        for (int e = 0; e < 20; e++) cv[e] = start + 32'(e) * step;
        pack();
    endtask

    task automatic do_load(input logic [31:0] mult);
        multiples = mult;
        memories_preprocess = 1'b1;
        tick();
        memories_preprocess = 1'b0;
    endtask

    initial begin
        int nv;
        logic [255:0] a_grp [3];
        tbl[0] = '{32'd0,   32'd1, 32'd3, 3};
        tbl[1] = '{32'd0,   32'd1, 32'd5, 3};
        tbl[2] = '{32'd0,   32'd1, 32'd0, 0};
        tbl[3] = '{32'd40,  32'd3, 32'd2, 2};
        tbl[4] = '{32'd250, 32'd1, 32'd1, 1};

        reset = 1'b1;
        memories_preprocess = 1'b0;
        write_enable = 1'b0;
        write_address = '0;
        write_data = '0;
        col_nos = '0;
        multiples = '0;
        tick();
        tick();
        chk("reset_vld", 256'(you_can_read), 256'(0));
        chk("reset_row", emap_row, 256'(0));
        reset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            write_enable = 1'b1;
            write_address = 8'(i);
            write_data = 32'(i) + 32'h100;
            pm[i] = 32'(i) + 32'h100;
            tick();
        end
        write_enable = 1'b0;

        for (int i = 0; i < 5; i++) begin
            set_cols(tbl[i].start, tbl[i].step);
            do_load(tbl[i].mult);
            nv = 0;
            for (int c = 1; c <= 6; c++) begin
                tick();
                if (you_can_read) begin
                    chk($sformatf("vec%0d_grp%0d", i, nv), emap_row, exp_group(nv));
                    nv++;
                end
            end
            chk($sformatf("vec%0d_nvalid", i), 256'(nv), 256'(tbl[i].nvalid));
        end
        set_cols(0, 1);
        chk("first_grp_literal", exp_group(2),
            {32'h110, 32'h111, 32'h112, 32'h113, 128'h0});

        set_cols(0, 1);
        for (int g = 0; g < 3; g++) a_grp[g] = exp_group(g);
        do_load(3);
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin
                set_cols(100, 1);
                multiples = 3;
                memories_preprocess = 1'b1;
            end else if (c == 3) begin
                set_cols(20, 1);
                multiples = 3;
                memories_preprocess = 1'b1;
            end else begin
                memories_preprocess = 1'b0;
            end
            tick();
            chk($sformatf("b2b_vld_c%0d", c), 256'(you_can_read), 256'(c <= 6));
            if (c <= 3) chk($sformatf("b2b_a_c%0d", c), emap_row, a_grp[c-1]);
            else if (c <= 6) chk($sformatf("b2b_b_c%0d", c), emap_row, exp_group(c-4));
        end
        memories_preprocess = 1'b0;

        set_cols(5, 1);
        write_enable = 1'b1;
        write_address = 8'd5;
        write_data = 32'hDEAD;
        do_load(2);
        pm[5] = 32'hDEAD;
        write_enable = 1'b0;
        tick();
        chk("wr_new_grp0", emap_row, exp_group(0));
        chk("wr_new_slot0", 256'(emap_row[255:224]), 256'(32'hDEAD));
        write_enable = 1'b1;
        write_address = 8'd13;
        write_data = 32'hBEEF;
        tick();
        write_enable = 1'b0;
        chk("wr_old_grp1", emap_row, exp_group(1));
        chk("wr_old_slot0", 256'(emap_row[255:224]), 256'(32'h10D));
        pm[13] = 32'hBEEF;
        tick();
        set_cols(13, 1);
        do_load(1);
        tick();
        chk("wr_later_slot0", 256'(emap_row[255:224]), 256'(32'hBEEF));
        tick();

        set_cols(0, 1);
        cv[0] = 32'h0000_0105;
        pack();
        do_load(1);
        tick();
`ifdef P_EMAP_BOUNDS_CHECK_EN
        chk("bounds_slot0", 256'(emap_row[255:224]), 256'(0));
`else
        chk("bounds_slot0", 256'(emap_row[255:224]), 256'(32'hDEAD));
`endif
        chk("bounds_grp0", emap_row, exp_group(0));
        tick();

        set_cols(0, 1);
        do_load(3);
        tick();
        chk("rst_pre_vld", 256'(you_can_read), 256'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_vld", 256'(you_can_read), 256'(0));
        chk("rst_mid_row", emap_row, 256'(0));
        tick();
        chk("rst_idle_vld", 256'(you_can_read), 256'(0));
        reset = 1'b1;
        multiples = 3;
        memories_preprocess = 1'b1;
        tick();
        reset = 1'b0;
        memories_preprocess = 1'b0;
        tick();
        chk("rst_vs_load_vld", 256'(you_can_read), 256'(0));
        do_load(1);
        tick();
        chk("rst_keep_p", emap_row, exp_group(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/p_emap_8.md
# p_emap_8

Gather unit for the P-vector element map in the sparse matrix-by-vector datapath. It holds the dense vector P in an internal register array. For each sparse row it receives a bundle of column indices, gathers the addressed P elements, and streams them out in groups of 8 for the row-by-vector multipliers. One instance serves one row-by-vector module; `you_can_read` tells the controller when a gathered group is valid.

## Interface
Parameters:
- `no_of_units`, default 8: multiplier lanes in the parent datapath. Informational only; it sets no widths.
- `element_width`, default 32: width of one P element.
- `no_of_elements_on_col_nos`, default 20: number of column indices per bundle (NC).
- `no_of_elements_in_output`, default 8: elements per output group (NO).
- `p_depth`, default 256: P vector entries. Address width AW = $clog2(p_depth).

Ports, in this order:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `memories_preprocess`  in  1  load strobe for `col_nos` and `multiples`.
- `write_enable`  in  1  P write strobe.
- `write_address`  in  AW  P write index.
- `write_data`  in  element_width  P write value.
- `col_nos`  in  NC*32  column indices; entry 0 sits in the MSBs.
- `emap_row`  out  NO*element_width  gathered group; slot 0 sits in the MSBs.
- `multiples`  in  32  number of groups to emit for this bundle.
- `you_can_read`  out  1  `emap_row` valid.

## Operation
- G = ceil(NC/NO), which is 3 with the default parameters. Effective group count m = min(`multiples`, G).
- Load: when `memories_preprocess`=1 and the block is idle or on its last output cycle, it latches `col_nos` and m. It then enters the EMIT state, with group counter k=0.
  - A load while busy on any other cycle is ignored.
  - A load with m=0 is ignored.
- EMIT: each cycle it registers group k onto `emap_row` and asserts `you_can_read`, then increments k. After group m-1 it returns to IDLE.
- Slot j of group k holds P[`col_nos` entry k*NO+j].
  - If k*NO+j ≥ NC (padding past the bundle), the slot is 0.
- P write: when `write_enable`=1, P[`write_address`] ← `write_data`. Writes are independent of EMIT.
- Read/write collision: a gather that reads the address being written in the same cycle returns the old value (read-first).
- States are IDLE and EMIT.
- Reset: state goes to IDLE, k=0, `you_can_read`=0, and `emap_row`=0. P contents are not reset.
- When `reset` coincides with a load, `reset` wins.

## Timing
- A load sampled at edge T puts group 0 on the outputs after edge T+1 and group m-1 after edge T+m.
- `you_can_read` is high for exactly m consecutive cycles.
- Back-to-back bundles: a load on the last EMIT cycle gives continuous `you_can_read` with no bubble.
- `emap_row` holds its last value when `you_can_read`=0. Consumers must sample only when `you_can_read`=1.
- A write at edge T is visible to gathers registered at edge T+1 and later.

## Configuration
- `P_EMAP_BOUNDS_CHECK_EN` defined: an index ≥ `p_depth`, using the full 32-bit value, returns 0 for that slot.
- `P_EMAP_BOUNDS_CHECK_EN` undefined: the index is truncated to its low AW bits, so it wraps modulo `p_depth` when `p_depth` is a power of two.

## Structure
- Package `p_emap_pkg` holds the default widths (element, index = 32) and the state enum {IDLE, EMIT}.
- Sub-module `p_emap_vector_ram` holds P storage: 1 write port and NO combinational read ports.
- The top level holds the control FSM, the bundle latch, the group slicing and the output register.

## Test plan
- P[i]=i+0x100 for all i; load `col_nos`=0..19, `multiples`=3. Required: 3 valid cycles, groups {0x100..0x107}, {0x108..0x10F}, {0x110..0x113,0,0,0,0}.
- Load with `multiples`=5. Required: clamped to 3 valid cycles. Load with `multiples`=0. Required: `you_can_read` stays 0.
- Issue a second load on the final EMIT cycle. Required: 6 consecutive valid cycles in total. A load mid-EMIT is ignored.
- Write P[5]=0xDEAD in the load cycle with index 5 in slot 0 of group 0. Required: new value appears. In the same cycle the group register samples. Required: old value.
- Index 0x0000_0105 with `p_depth`=256. Required: 0 with `P_EMAP_BOUNDS_CHECK_EN`, P[5] without it.
- Assert `reset` mid-EMIT. Required: next cycle `you_can_read`=0 and `emap_row`=0; P contents are retained.
